treasure_detect_ctrl: RTL and testbench

//  Frame-level sequencer for the treasure image processor. On a request from the Arduino it

---
 rtl/treasure_detect_ctrl.sv | 162 ++++++++++++++++
 tb/tb_treasure_detect_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/treasure_detect_ctrl.sv
// treasure_detect_ctrl
//   Frame-level sequencer for the treasure image processor. An Arduino request
//   starts a run: the partial frame in flight is discarded, then whole frames are
//   gated through the processor and the colour/shape verdict captured just before
//   each vertical-sync falling edge is evaluated. A verdict is reported once it has
//   been seen CONFIRM_FRAMES frames in a row, or a timeout is reported after
//   MAX_FRAMES frames. The report is returned over a 4-phase REQ/ACK handshake.
//
//   Optional build macro TREASURE_CTRL_DEBUG_EN adds DBG_STATE (FSM state) and
//   DBG_FRAMES (live frame counter) outputs; without it those ports are absent.
`timescale 1ns/1ps

module treasure_detect_ctrl #(
   parameter int CONFIRM_FRAMES = 3,
   parameter int MAX_FRAMES     = 30
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       VGA_VSYNC_NEG,
   input  logic       COLOR_DONE,
   input  logic       SHAPE_DONE,
   input  logic [1:0] COLOR_CODE,
   input  logic [1:0] SHAPE_CODE,
   input  logic       ARD_REQ,
   output logic       ARD_ACK,
   output logic [7:0] RESULT,
   output logic       PROC_ENABLE,
   output logic       BUSY
`ifdef TREASURE_CTRL_DEBUG_EN
   ,
   output logic [1:0] DBG_STATE,
   output logic [7:0] DBG_FRAMES
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_VS = 2'd1,
      ACQUIRE = 2'd2,
      REPORT  = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic       vs_q;
   logic       fb;

   logic       done_c_q;
   logic       done_s_q;
   logic [1:0] color_q;
   logic [1:0] shape_q;
   logic [3:0] verdict;

   logic [7:0] frame_cnt;
   logic [7:0] frame_nxt;
   logic [7:0] frame_inc;
   logic [3:0] agree_cnt;
   logic [3:0] agree_nxt;
   logic [3:0] agree_new;
   logic [3:0] cand;
   logic [3:0] cand_nxt;
   logic [7:0] result_nxt;

   // Frame boundary is the falling edge of the active-low vsync.
   assign fb = vs_q & ~VGA_VSYNC_NEG;

   // The processor clears its results during vsync, so only the values seen
   // while vsync is inactive are kept; at the boundary these are the last ones.
   always_ff @(posedge CLK) begin
      if (VGA_VSYNC_NEG) begin
         done_c_q <= COLOR_DONE;
         done_s_q <= SHAPE_DONE;
         color_q  <= COLOR_CODE;
         shape_q  <= SHAPE_CODE;
      end
   end

   // No colour means nothing was seen; colour without shape reports colour only.
   assign verdict = !done_c_q ? 4'h0 :
                    !done_s_q ? {2'b00, color_q} :
                                {shape_q, color_q};

   assign frame_inc = (frame_cnt == 8'hFF) ? frame_cnt : frame_cnt + 8'd1;
   assign agree_new = (verdict == cand && agree_cnt != 4'd0) ? agree_cnt + 4'd1 : 4'd1;

   // Next-state, counter and report decode; a dropped request wins over any decision.
   always_comb begin
      state_nxt  = state;
      frame_nxt  = frame_cnt;
      agree_nxt  = agree_cnt;
      cand_nxt   = cand;
      result_nxt = RESULT;
      case (state)
         IDLE: begin
            if (ARD_REQ && !ARD_ACK) state_nxt = WAIT_VS;
         end
         WAIT_VS: begin
            if (!ARD_REQ) begin
               state_nxt = IDLE;
            end else if (fb) begin
               state_nxt = ACQUIRE;
               frame_nxt = 8'd0;
               agree_nxt = 4'd0;
               cand_nxt  = 4'd0;
            end
         end
         ACQUIRE: begin
            if (!ARD_REQ) begin
               state_nxt = IDLE;
            end else if (fb) begin
               frame_nxt = frame_inc;
               agree_nxt = agree_new;
               cand_nxt  = verdict;
               if (agree_new == 4'(CONFIRM_FRAMES)) begin
                  state_nxt  = REPORT;
                  result_nxt = {4'b0000, verdict};
               end else if (frame_inc == 8'(MAX_FRAMES)) begin
                  state_nxt  = REPORT;
                  result_nxt = 8'h10;
               end
            end
         end
         REPORT: begin
            if (!ARD_REQ) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, counters and registered outputs; outputs are decoded from the next state
   // so they change on the same edge as the state itself.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state       <= IDLE;
         vs_q        <= 1'b0;
         frame_cnt   <= 8'd0;
         agree_cnt   <= 4'd0;
         cand        <= 4'd0;
         RESULT      <= 8'h00;
         ARD_ACK     <= 1'b0;
         PROC_ENABLE <= 1'b0;
         BUSY        <= 1'b0;
      end else begin
         state       <= state_nxt;
         vs_q        <= VGA_VSYNC_NEG;
         frame_cnt   <= frame_nxt;
         agree_cnt   <= agree_nxt;
         cand        <= cand_nxt;
         RESULT      <= result_nxt;
         ARD_ACK     <= (state == REPORT) && (state_nxt == REPORT);
         PROC_ENABLE <= (state_nxt == ACQUIRE);
         BUSY        <= (state_nxt != IDLE);
      end
   end

`ifdef TREASURE_CTRL_DEBUG_EN
   assign DBG_STATE  = state;
   assign DBG_FRAMES = frame_cnt;
`endif

endmodule

// File: tb/tb_treasure_detect_ctrl.sv
// Bench for treasure_detect_ctrl: frames of colour/shape verdicts are driven with
// randomised frame lengths and garbage during vsync, and every run is compared to a
// run-length reference of the confirm/timeout rules.
`timescale 1ns/1ps

module tb_treasure_detect_ctrl;

   localparam int CONFIRM = 3;
   localparam int MAXF    = 30;

   typedef struct packed {
      logic [1:0] c;
      logic [1:0] s;
      logic       dc;
      logic       ds;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       vs;
   logic       cd;
   logic       sd;
   logic [1:0] cc;
   logic [1:0] sc;
   logic       req;
   logic       ack;
   logic [7:0] result;
   logic       pe;
   logic       busy;

   int         checks = 0;
   int         passed = 0;
   logic [7:0] model_result;
   frame_t     fq[$];

   treasure_detect_ctrl #(.CONFIRM_FRAMES(CONFIRM), .MAX_FRAMES(MAXF)) dut (
      .CLK(clk), .RESET(rst), .VGA_VSYNC_NEG(vs),
      .COLOR_DONE(cd), .SHAPE_DONE(sd), .COLOR_CODE(cc), .SHAPE_CODE(sc),
      .ARD_REQ(req), .ARD_ACK(ack), .RESULT(result),
      .PROC_ENABLE(pe), .BUSY(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic garbage;
      cc = 2'($urandom);
      sc = 2'($urandom);
      cd = 1'($urandom);
      sd = 1'($urandom);
   endtask

   function automatic frame_t mk(input logic [1:0] c, input logic [1:0] s,
                                 input logic dc, input logic ds);
      frame_t f;
      f.c = c; f.s = s; f.dc = dc; f.ds = ds;
      return f;
   endfunction

   function automatic logic [3:0] verdict(input frame_t f);
      if (!f.dc) return 4'h0;
      if (!f.ds) return {2'b00, f.c};
      return {f.s, f.c};
   endfunction

   // Index of the deciding frame and the report it produces.
   function automatic void predict(output int idx, output logic [7:0] res);
      int run_len;
      logic [3:0] prev;
      logic [3:0] v;
      idx = -1; res = 8'h00; run_len = 0; prev = 4'h0;
      for (int i = 0; i < fq.size(); i++) begin
         v = verdict(fq[i]);
         run_len = (i > 0 && v == prev) ? run_len + 1 : 1;
         prev = v;
         if (run_len == CONFIRM) begin idx = i; res = {4'h0, v}; return; end
         if (i + 1 == MAXF) begin idx = i; res = 8'h10; return; end
      end
   endfunction

   task automatic run_frames(input string tag, input bit abort);
      int idx;
      logic [7:0] exp_res;
      bit decided;
      predict(idx, exp_res);
      decided = 1'b0;
      req = 1'b1;
      tick;
      checks++;
      if ({busy, pe, ack} !== 3'b100) $display("FAIL %s wait_vs: busy/pe/ack=%b want 100", tag, {busy, pe, ack});
      else passed++;
      vs = 1'b1; garbage;
      repeat ($urandom_range(1, 4)) tick;
      vs = 1'b0; garbage;
      tick;
      checks++;
      if ({busy, pe, ack} !== 3'b110) $display("FAIL %s acquire_entry: busy/pe/ack=%b want 110", tag, {busy, pe, ack});
      else passed++;
      tick;
      for (int i = 0; i < fq.size() && !decided; i++) begin
         vs = 1'b1; cc = fq[i].c; sc = fq[i].s; cd = fq[i].dc; sd = fq[i].ds;
         repeat ($urandom_range(2, 6)) tick;
         vs = 1'b0; garbage;
         if (abort && i == idx) req = 1'b0;
         tick;
         if (i != idx) begin
            checks++;
            if ({busy, pe, ack} !== 3'b110) $display("FAIL %s frame%0d: busy/pe/ack=%b want 110", tag, i, {busy, pe, ack});
            else passed++;
            tick;
         end else if (abort) begin
            decided = 1'b1;
            checks++;
            if ({busy, pe, ack} !== 3'b000 || result !== model_result)
               $display("FAIL %s abort_idle: busy/pe/ack=%b result=%h want 000 result=%h", tag, {busy, pe, ack}, result, model_result);
            else passed++;
            tick;
            checks++;
            if (ack !== 1'b0) $display("FAIL %s abort_no_ack: ack=%b want 0", tag, ack);
            else passed++;
         end else begin
            decided = 1'b1;
            checks++;
            if ({busy, pe, ack} !== 3'b100 || result !== exp_res)
               $display("FAIL %s report_entry: busy/pe/ack=%b result=%h want 100 result=%h", tag, {busy, pe, ack}, result, exp_res);
            else passed++;
            tick;
            checks++;
            if (ack !== 1'b1 || result !== exp_res)
               $display("FAIL %s report_ack: ack=%b result=%h want 1 result=%h", tag, ack, result, exp_res);
            else passed++;
            vs = 1'b1;
            repeat ($urandom_range(0, 3)) tick;
            checks++;
            if ({busy, pe, ack} !== 3'b101 || result !== exp_res)
               $display("FAIL %s report_hold: busy/pe/ack=%b result=%h want 101 result=%h", tag, {busy, pe, ack}, result, exp_res);
            else passed++;
            req = 1'b0;
            tick;
            checks++;
            if ({busy, pe, ack} !== 3'b000 || result !== exp_res)
               $display("FAIL %s release: busy/pe/ack=%b result=%h want 000 result=%h", tag, {busy, pe, ack}, result, exp_res);
            else passed++;
            model_result = exp_res;
         end
      end
      req = 1'b0;
      vs  = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1; req = 1'b0; vs = 1'b1; garbage;
      tick; tick;
      checks++;
      if ({ack, pe, busy} !== 3'b000 || result !== 8'h00)
         $display("FAIL reset: ack/pe/busy=%b result=%h want 000 result=00", {ack, pe, busy}, result);
      else passed++;
      rst = 1'b0;
      tick; tick;
      checks++;
      if ({ack, pe, busy} !== 3'b000 || result !== 8'h00)
         $display("FAIL idle_after_reset: ack/pe/busy=%b result=%h want 000 result=00", {ack, pe, busy}, result);
      else passed++;
      model_result = 8'h00;
   endtask

   task automatic test_confirm_red_square;
      fq.delete();
      repeat (MAXF) fq.push_back(mk(2'b01, 2'b11, 1'b1, 1'b1));
      run_frames("red_square", 1'b0);
      tick;
      checks++;
      if (result !== 8'h0D) $display("FAIL red_square_held: result=%h want 0d", result);
      else passed++;
   endtask

   task automatic test_timeout_alternating;
      fq.delete();
      for (int i = 0; i < MAXF; i++)
         fq.push_back(mk((i % 2) ? 2'b10 : 2'b01, 2'b11, 1'b1, 1'b1));
      run_frames("timeout", 1'b0);
      checks++;
      if (result !== 8'h10) $display("FAIL timeout_code: result=%h want 10", result);
      else passed++;
   endtask

   task automatic test_confirm_beats_timeout;
      fq.delete();
      for (int i = 0; i < MAXF - 3; i++)
         fq.push_back(mk((i % 2) ? 2'b10 : 2'b01, 2'b11, 1'b1, 1'b1));
      repeat (3) fq.push_back(mk(2'b10, 2'b10, 1'b1, 1'b1));
      run_frames("confirm_last", 1'b0);
      checks++;
      if (result !== 8'h0A) $display("FAIL confirm_over_timeout: result=%h want 0a", result);
      else passed++;
   endtask

   task automatic test_abort;
      fq.delete();
      repeat (MAXF) fq.push_back(mk(2'b01, 2'b11, 1'b1, 1'b1));
      run_frames("abort", 1'b1);
   endtask

   task automatic test_reset_mid_acquire;
      req = 1'b1; tick;
      vs = 1'b1; garbage; tick; tick;
      vs = 1'b0; tick; tick;
      vs = 1'b1; cc = 2'b01; sc = 2'b11; cd = 1'b1; sd = 1'b1;
      tick; tick;
      checks++;
      if (pe !== 1'b1) $display("FAIL pre_reset_acquire: pe=%b want 1", pe);
      else passed++;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({ack, pe, busy} !== 3'b000 || result !== 8'h00)
         $display("FAIL async_reset: ack/pe/busy=%b result=%h want 000 result=00", {ack, pe, busy}, result);
      else passed++;
      req = 1'b0;
      tick;
      rst = 1'b0;
      tick;
      model_result = 8'h00;
      fq.delete();
      repeat (MAXF) fq.push_back(mk(2'b01, 2'b11, 1'b1, 1'b1));
      run_frames("after_reset", 1'b0);
   endtask

   task automatic test_color_only_blue;
      fq.delete();
      repeat (MAXF) fq.push_back(mk(2'b10, 2'($urandom), 1'b1, 1'b0));
      run_frames("blue_only", 1'b0);
      checks++;
      if (result !== 8'h02) $display("FAIL blue_only_code: result=%h want 02", result);
      else passed++;
   endtask

   task automatic test_nothing_seen;
      fq.delete();
      repeat (MAXF) fq.push_back(mk(2'($urandom), 2'($urandom), 1'b0, 1'($urandom)));
      run_frames("nothing", 1'b0);
      checks++;
      if (result !== 8'h00) $display("FAIL nothing_code: result=%h want 00", result);
      else passed++;
   endtask

   task automatic test_back_to_back;
      fq.delete();
      repeat (MAXF) fq.push_back(mk(2'b01, 2'b10, 1'b1, 1'b1));
      run_frames("b2b_first", 1'b0);
      fq.delete();
      repeat (MAXF) fq.push_back(mk(2'b10, 2'b01, 1'b1, 1'b1));
      run_frames("b2b_second", 1'b0);
   endtask

   task automatic test_random;
      frame_t f;
      for (int r = 0; r < 8; r++) begin
         fq.delete();
         f = mk(2'b00, 2'b00, 1'b0, 1'b0);
         for (int i = 0; i < MAXF; i++) begin
            if (i == 0 || $urandom_range(0, 1) == 0) begin
               f.c  = 2'($urandom_range(0, 2));
               f.s  = 2'($urandom);
               f.dc = ($urandom_range(0, 3) != 0);
               f.ds = ($urandom_range(0, 3) != 0);
            end
            fq.push_back(f);
         end
         run_frames($sformatf("random%0d", r), ($urandom_range(0, 4) == 0));
      end
   endtask

   initial begin
      test_reset;
      test_confirm_red_square;
      test_timeout_alternating;
      test_confirm_beats_timeout;
      test_abort;
      test_reset_mid_acquire;
      test_color_only_blue;
      test_nothing_seen;
      test_back_to_back;
      test_random;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
